// File: rtl/mips_pkg.sv
// Shared CPU package: opcode/funct encodings, divider state type and ALU helpers.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_J     = 6'h02;
  localparam logic [5:0] OPCODE_JAL   = 6'h03;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_BNE   = 6'h05;
  localparam logic [5:0] OPCODE_ADDIU = 6'h09;
  localparam logic [5:0] OPCODE_SLTI  = 6'h0A;
  localparam logic [5:0] OPCODE_SLTIU = 6'h0B;
  localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
  localparam logic [5:0] OPCODE_ORI   = 6'h0D;
  localparam logic [5:0] OPCODE_XORI  = 6'h0E;
  localparam logic [5:0] OPCODE_LUI   = 6'h0F;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_SLLV  = 6'h04;
  localparam logic [5:0] FUNCT_SRLV  = 6'h06;
  localparam logic [5:0] FUNCT_SRAV  = 6'h07;
  localparam logic [5:0] FUNCT_JR    = 6'h08;
  localparam logic [5:0] FUNCT_JALR  = 6'h09;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;
  localparam logic [5:0] FUNCT_NOP   = 6'h3F;

  typedef enum logic {
    IDLE    = 1'b0,
    DIV_RUN = 1'b1
  } div_state_t;

  // Operations that touch HI/LO and therefore must wait for a running divide.
  function automatic logic is_hilo_op(input logic [5:0] fn);
    return fn inside {FUNCT_MFHI, FUNCT_MFLO, FUNCT_MTHI, FUNCT_MTLO,
                      FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                input logic is_signed);
    return (is_signed && x[XLEN-1]) ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mips_div_iter.sv
// Restoring divider, one quotient bit per cycle for 32 cycles; signed mode works
// on magnitudes and fixes signs on the final, combinationally presented step.
module mips_div_iter
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            signed_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic [4:0]      count_q;
  logic            running_q, neg_quo_q, neg_rem_q;

  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] rem_next, quo_next;

  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    ge       = (shifted >= {1'b0, dvsr_q});
    rem_next = ge ? (shifted[XLEN-1:0] - dvsr_q) : shifted[XLEN-1:0];
    quo_next = {quo_q[XLEN-2:0], ge};
  end

  // Outputs are the result of the step being taken this cycle, so the caller
  // can commit them on the same edge that ends the 32nd iteration.
  assign done      = running_q && (count_q == 5'd31);
  assign quotient  = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
  assign remainder = neg_rem_q ? (~rem_next + 1'b1) : rem_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (start && !running_q) begin
      rem_q     <= '0;
      quo_q     <= magnitude(dividend, signed_op);
      dvsr_q    <= magnitude(divisor, signed_op);
      count_q   <= '0;
      running_q <= 1'b1;
      // A zero divisor yields all-ones quotient regardless of sign.
      neg_quo_q <= signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]) && (divisor != '0);
      neg_rem_q <= signed_op && dividend[XLEN-1];
    end else if (running_q) begin
      rem_q   <= rem_next;
      quo_q   <= quo_next;
      count_q <= count_q + 5'd1;
      if (count_q == 5'd31) running_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mips_alu.sv
// MIPS execute-stage ALU: combinational integer ops, single-cycle multiply and
// HI/LO moves, and a 32-cycle iterative divide that stalls HI/LO users.
module mips_alu
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      fncode,
  input  logic            op_valid,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      shamt,
  output logic [XLEN-1:0] result,
  output logic            stall,
  output logic            busy
);

  div_state_t      state;
  logic [XLEN-1:0] hi, lo;
  logic [63:0]     prod_s, prod_u;
  logic            div_start, div_signed, div_done;
  logic [XLEN-1:0] div_quo, div_rem;

  assign busy  = (state == DIV_RUN);
  assign stall = busy && op_valid && is_hilo_op(fncode);

  assign div_start  = op_valid && (state == IDLE) &&
                      ((fncode == FUNCT_DIV) || (fncode == FUNCT_DIVU));
  assign div_signed = (fncode == FUNCT_DIV);

  // The low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  mips_div_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .signed_op (div_signed),
    .dividend  (a),
    .divisor   (b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // NOTE: result gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    result = '0;
    case (fncode)
      FUNCT_ADDU: result = a + b;
      FUNCT_SUBU: result = a - b;
      FUNCT_AND:  result = a & b;
      FUNCT_OR:   result = a | b;
      FUNCT_XOR:  result = a ^ b;
      FUNCT_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
      FUNCT_SLTU: result = {31'd0, (a < b)};
      FUNCT_SLL:  result = b << shamt;
      FUNCT_SRL:  result = b >> shamt;
      FUNCT_SRA:  result = $signed(b) >>> shamt;
      FUNCT_SLLV: result = b << a[4:0];
      FUNCT_SRLV: result = b >> a[4:0];
      FUNCT_SRAV: result = $signed(b) >>> a[4:0];
      FUNCT_MFHI: result = hi;
      FUNCT_MFLO: result = lo;
      default:    result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (div_start) state <= DIV_RUN;
        DIV_RUN: if (div_done)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Divide completion wins; any HI/LO op in that cycle is stalled anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (div_done) begin
      hi <= div_rem;
      lo <= div_quo;
    end else if (op_valid && !stall) begin
      case (fncode)
        FUNCT_MTHI:  hi <= a;
        FUNCT_MTLO:  lo <= a;
        FUNCT_MULT:  {hi, lo} <= prod_s;
        FUNCT_MULTU: {hi, lo} <= prod_u;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: table of combinational vectors plus
// directed sequences for HI/LO, multiply, divide, stall and reset corners.
module tb_mips_alu;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  fncode;
  logic        op_valid;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        stall, busy;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  mips_alu dut (
    .clk      (clk),
    .reset    (reset),
    .fncode   (fncode),
    .op_valid (op_valid),
    .a        (a),
    .b        (b),
    .shamt    (shamt),
    .result   (result),
    .stall    (stall),
    .busy     (busy)
  );

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] fn, input logic [31:0] va, input logic [31:0] vb,
                       input logic [4:0] sh, input logic v);
    fncode = fn; a = va; b = vb; shamt = sh; op_valid = v;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    drive(FUNCT_MFHI, 32'd0, 32'd0, 5'd0, 1'b1);
    check({tag, "_hi"}, result, exp_hi);
    drive(FUNCT_MFLO, 32'd0, 32'd0, 5'd0, 1'b1);
    check({tag, "_lo"}, result, exp_lo);
  endtask

  // Issue a divide, then hold an HI/LO read and count the stalled cycles.
  task automatic run_div(input string tag, input logic [5:0] fn, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cnt;
    drive(fn, va, vb, 5'd0, 1'b1);
    check({tag, "_stall_idle"}, {31'd0, stall}, 32'd0);
    tick();
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    drive(FUNCT_MFLO, 32'd0, 32'd0, 5'd0, 1'b1);
    cnt = 0;
    while (stall && cnt < 40) begin
      cnt++;
      tick();
    end
    check({tag, "_stall_cycles"}, cnt, 32'd32);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_mflo_after"}, result, exp_lo);
    read_hilo(tag, exp_hi, exp_lo);
  endtask

  initial begin
    int cnt;

    vecs[0]  = '{FUNCT_ADDU, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0};
    vecs[1]  = '{FUNCT_SLT,  32'hFFFF_FFFF, 32'h1,         5'd0,  32'h1};
    vecs[2]  = '{FUNCT_SLTU, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0};
    vecs[3]  = '{FUNCT_SRA,  32'h0,         32'h8000_0000, 5'd4,  32'hF800_0000};
    vecs[4]  = '{FUNCT_SRLV, 32'h4,         32'h8000_0000, 5'd0,  32'h0800_0000};
    vecs[5]  = '{FUNCT_SUBU, 32'h5,         32'h7,         5'd0,  32'hFFFF_FFFE};
    vecs[6]  = '{FUNCT_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h00F0_00F0};
    vecs[7]  = '{FUNCT_OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'hFFF0_FFF0};
    vecs[8]  = '{FUNCT_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'hFF00_FF00};
    vecs[9]  = '{FUNCT_SLL,  32'h0,         32'h1,         5'd31, 32'h8000_0000};
    vecs[10] = '{FUNCT_SRL,  32'h0,         32'h8000_0000, 5'd31, 32'h1};
    vecs[11] = '{FUNCT_SLLV, 32'h24,        32'h3,         5'd0,  32'h30};
    vecs[12] = '{FUNCT_SRAV, 32'h1,         32'h8000_0000, 5'd0,  32'hC000_0000};
    vecs[13] = '{FUNCT_JR,   32'h5,         32'h6,         5'd0,  32'h0};
    vecs[14] = '{FUNCT_NOP,  32'h5,         32'h6,         5'd0,  32'h0};
    vecs[15] = '{6'h27,      32'h5,         32'h6,         5'd0,  32'h0};
    vecs[16] = '{FUNCT_SLT,  32'h1,         32'hFFFF_FFFF, 5'd0,  32'h0};
    vecs[17] = '{FUNCT_SLTU, 32'h1,         32'hFFFF_FFFF, 5'd0,  32'h1};

    // Reset: result stays combinational while reset is held.
    reset = 1'b1;
    drive(FUNCT_ADDU, 32'd2, 32'd3, 5'd0, 1'b1);
    tick();
    tick();
    check("reset_result_comb", result, 32'd5);
    reset = 1'b0;
    drive(FUNCT_MFHI, 32'd0, 32'd0, 5'd0, 1'b1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    read_hilo("reset", 32'd0, 32'd0);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].sh, 1'b1);
      check($sformatf("vec%0d", i), result, vecs[i].exp);
    end

    // HI/LO moves; op_valid low must not write.
    drive(FUNCT_MTHI, 32'h1234, 32'd0, 5'd0, 1'b1);
    tick();
    drive(FUNCT_MTLO, 32'h5678, 32'd0, 5'd0, 1'b1);
    tick();
    drive(FUNCT_MTLO, 32'h99, 32'd0, 5'd0, 1'b0);
    tick();
    read_hilo("mt", 32'h1234, 32'h5678);

    drive(FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b1);
    tick();
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    drive(FUNCT_MULTU, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b1);
    tick();
    read_hilo("multu", 32'h6, 32'hFFFF_FFEB);

    // DIV with op_valid low must not start.
    drive(FUNCT_DIV, 32'd9, 32'd3, 5'd0, 1'b0);
    tick();
    check("div_invalid_busy", {31'd0, busy}, 32'd0);
    read_hilo("div_invalid", 32'h6, 32'hFFFF_FFEB);

    run_div("div_m7_2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("divu_by0", FUNCT_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_div("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // Non-HI/LO ops proceed during a divide; HI/LO ops stall.
    drive(FUNCT_DIVU, 32'd100, 32'd7, 5'd0, 1'b1);
    tick();
    drive(FUNCT_ADDU, 32'd10, 32'd20, 5'd0, 1'b1);
    check("during_div_addu", result, 32'd30);
    check("during_div_addu_stall", {31'd0, stall}, 32'd0);
    tick();
    check("during_div_busy", {31'd0, busy}, 32'd1);
    drive(FUNCT_MTHI, 32'hDEAD, 32'd0, 5'd0, 1'b1);
    check("during_div_mthi_stall", {31'd0, stall}, 32'd1);
    drive(FUNCT_ADDU, 32'd1, 32'd1, 5'd0, 1'b1);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      tick();
    end
    check("divu_100_7_wait", {31'd0, busy}, 32'd0);
    read_hilo("divu_100_7", 32'd2, 32'd14);

    // Reset at cycle 10 of a divide aborts it.
    drive(FUNCT_DIV, 32'd100, 32'd3, 5'd0, 1'b1);
    tick();
    drive(FUNCT_ADDU, 32'd0, 32'd0, 5'd0, 1'b1);
    repeat (9) tick();
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    drive(FUNCT_MFLO, 32'd0, 32'd0, 5'd0, 1'b1);
    check("abort_stall", {31'd0, stall}, 32'd0);
    read_hilo("abort", 32'd0, 32'd0);
    repeat (40) tick();
    read_hilo("abort_late", 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
